sl_tx_fifo: RTL and testbench

SL_TX_FIFO -- requirements
Module: sl_tx_fifo

---
 rtl/sl_tx_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_sl_tx_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sl_tx_fifo.sv
// ============================================================================
// Module   : sl_tx_fifo
// Purpose  : Queued SL-line transmitter. Words are sent LSB first on two
//            strobe lines, followed by a parity phase, a stop phase and a gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sl_tx_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 8,
    parameter int LEN_W      = $clog2(DATA_W + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_W-1:0]                 tx_data,
    input  logic [LEN_W-1:0]                  tx_len,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    input  logic [DIV_W-1:0]                  half_period,
    output logic                              sl0,
    output logic                              sl1,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              len_err
);

    localparam int c_LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_ENT_W = LEN_W + DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BIT_LO = 3'd1,
        ST_BIT_HI = 3'd2,
        ST_PAR    = 3'd3,
        ST_PAR_HI = 3'd4,
        ST_STOP   = 3'd5,
        ST_GAP    = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_count;
    logic               r_len_err;

    logic               w_accept;
    logic               w_len_ok;
    logic               w_store;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_head;

    // ------------------------------------------------------------------
    // Serializer state
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [DATA_W-1:0]  r_shift;
    logic [LEN_W-1:0]   r_bits;
    logic [DIV_W-1:0]   r_period;
    logic [DIV_W-1:0]   r_timer;
    logic               r_par0;
    logic               r_par1;
    logic               r_sl0;
    logic               r_sl1;
    logic               w_sl0;
    logic               w_sl1;
    logic               w_done;
    logic [DIV_W-1:0]   w_period;

    assign tx_ready   = (r_count != c_LVL_W'(FIFO_DEPTH));
    assign w_accept   = tx_valid && tx_ready;
    assign w_len_ok   = (tx_len != '0) && ({1'b0, tx_len} <= (LEN_W + 1)'(DATA_W));
    assign w_store    = w_accept && w_len_ok;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_done     = (r_timer == '0);
    assign w_period   = (half_period == '0) ? DIV_W'(1) : half_period;

    assign fifo_level = r_count;
    assign len_err    = r_len_err;
    assign busy       = (r_state != ST_IDLE);
    assign sl0        = r_sl0;
    assign sl1        = r_sl1;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= {tx_len, tx_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= w_accept && !w_len_ok;
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_LVL_W'(w_store) - c_LVL_W'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and line decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_sl0        = 1'b1;
        w_sl1        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_BIT_LO;
                end
            end
            ST_BIT_LO: begin
                w_sl0 = r_shift[0];
                w_sl1 = ~r_shift[0];
                if (w_done) w_state_next = ST_BIT_HI;
            end
            ST_BIT_HI: begin
                if (w_done) w_state_next = (r_bits == LEN_W'(1)) ? ST_PAR : ST_BIT_LO;
            end
            ST_PAR: begin
                w_sl0 = r_par0;
                w_sl1 = r_par1;
                if (w_done) w_state_next = ST_PAR_HI;
            end
            ST_PAR_HI: begin
                if (w_done) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                w_sl0 = 1'b0;
                w_sl1 = 1'b0;
                if (w_done) w_state_next = ST_GAP;
            end
            ST_GAP: begin
                if (w_done) w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Lines are the registered decode of the current state, so they trail
    // the state register by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bits   <= '0;
            r_period <= DIV_W'(1);
            r_timer  <= '0;
            r_par0   <= 1'b1;
            r_par1   <= 1'b0;
            r_sl0    <= 1'b1;
            r_sl1    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_sl0   <= w_sl0;
            r_sl1   <= w_sl1;
            if (w_pop) begin
                r_shift  <= w_head[DATA_W-1:0];
                r_bits   <= w_head[c_ENT_W-1:DATA_W];
                r_period <= w_period;
                r_timer  <= w_period - DIV_W'(1);
                r_par0   <= 1'b1;
                r_par1   <= 1'b0;
            end else if (r_state != ST_IDLE) begin
                if (w_done) begin
                    r_timer <= r_period - DIV_W'(1);
                    if (r_state == ST_BIT_LO) begin
                        if (r_shift[0]) r_par1 <= ~r_par1;
                        else            r_par0 <= ~r_par0;
                    end
                    if (r_state == ST_BIT_HI) begin
                        r_shift <= r_shift >> 1;
                        r_bits  <= r_bits - LEN_W'(1);
                    end
                end else begin
                    r_timer <= r_timer - DIV_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sl_tx_fifo.sv
// ============================================================================
// Module   : tb_sl_tx_fifo
// Purpose  : Self-checking bench for sl_tx_fifo (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sl_tx_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] tx_data = '0;
    logic [5:0]  tx_len = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  half_period = 8'd1;
    logic        sl0;
    logic        sl1;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        len_err;

    int n_cmp = 0;
    int n_err = 0;

    sl_tx_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_len      (tx_len),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .half_period (half_period),
        .sl0         (sl0),
        .sl1         (sl1),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .len_err     (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [5:0]  len;
        logic [7:0]  hp;
        int          ncyc;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        int cnt;
        int idx;
        logic pre;

        // Expected sl0/sl1 per frame cycle, bit c = cycle c (P=1).
        vecs[0] = '{32'h0000_0001, 6'd2, 8'd1, 8,  16'h00AB, 16'h00BE};
        vecs[1] = '{32'h0000_0002, 6'd2, 8'd1, 8,  16'h00AE, 16'h00BB};
        vecs[2] = '{32'h0000_0000, 6'd1, 8'd0, 6,  16'h002A, 16'h002B};
        vecs[3] = '{32'h0000_0005, 6'd3, 8'd1, 10, 16'h02BB, 16'h02AE};
        vecs[4] = '{32'h0000_00F3, 6'd2, 8'd1, 8,  16'h00BF, 16'h00AA};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_lines", {sl0, sl1}, 2'b11);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_len_err", len_err, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Short frames, per-cycle line sequence and latency
        for (int v = 0; v < 5; v++) begin
            tx_data     = vecs[v].data;
            tx_len      = vecs[v].len;
            half_period = vecs[v].hp;
            tx_valid    = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_busy_start", v), busy, 1'b1);
            for (int c = 0; c < vecs[v].ncyc; c++) begin
                @(negedge clk);
                check($sformatf("v%0d_cyc%0d_lines", v, c), {sl0, sl1},
                      {vecs[v].e0[c], vecs[v].e1[c]});
            end
            @(negedge clk);
            check($sformatf("v%0d_idle_lines", v), {sl0, sl1}, 2'b11);
            check($sformatf("v%0d_idle_busy", v), busy, 1'b0);
            check($sformatf("v%0d_level", v), fifo_level, 3'd0);
        end

        // 32-bit all-ones frame at P=3; half_period change mid-frame ignored
        tx_data     = 32'hFFFF_FFFF;
        tx_len      = 6'd32;
        half_period = 8'd3;
        tx_valid    = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        half_period = 8'd5;
        idx = 0;
        while (busy && idx < 1000) begin
            if (idx == 194) check("p3_par_lines", {sl0, sl1}, 2'b10);
            if (idx == 200) check("p3_stop_lines", {sl0, sl1}, 2'b00);
            @(negedge clk);
            idx++;
        end
        check("p3_frame_cycles", idx, 204);
        repeat (3) @(negedge clk);

        // FIFO fill with tx_valid held, P=4, len=1
        half_period = 8'd4;
        tx_len      = 6'd1;
        n           = 0;
        tx_data     = 32'd0;
        tx_valid    = 1'b1;
        for (int g = 0; g < 20 && n < 5; g++) begin
            pre = tx_ready;
            @(negedge clk);
            if (pre) begin
                n++;
                tx_data = n;
            end
        end
        check("fill_accepted", n, 5);
        check("fill_level", fifo_level, 3'd4);
        check("fill_ready", tx_ready, 1'b0);
        cnt = 0;
        while (!tx_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("fill_stall_cycles", cnt, 22);
        check("fill_level_after_pop", fifo_level, 3'd3);
        @(negedge clk);
        tx_valid = 1'b0;
        check("fill_sixth_level", fifo_level, 3'd4);
        cnt = 0;
        while ((fifo_level != 3'd0 || busy) && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("fill_drained", (cnt < 1000), 1'b1);
        repeat (2) @(negedge clk);

        // Illegal lengths
        tx_data  = 32'hA5A5_A5A5;
        tx_len   = 6'd0;
        tx_valid = 1'b1;
        @(negedge clk);
        check("lerr0_pulse", len_err, 1'b1);
        check("lerr0_level", fifo_level, 3'd0);
        tx_len = 6'd33;
        @(negedge clk);
        tx_valid = 1'b0;
        check("lerr33_pulse", len_err, 1'b1);
        check("lerr33_level", fifo_level, 3'd0);
        @(negedge clk);
        check("lerr_clear", len_err, 1'b0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if ({sl0, sl1} != 2'b11 || busy || fifo_level != 3'd0) cnt++;
            @(negedge clk);
        end
        check("lerr_lines_quiet", cnt, 0);

        // Reset asserted during BIT_LO of the first word, two more queued
        half_period = 8'd2;
        tx_len      = 6'd3;
        tx_data     = 32'h2;
        tx_valid    = 1'b1;
        @(negedge clk);
        tx_data = 32'h7;
        @(negedge clk);
        tx_data = 32'h1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("rst_mid_level", fifo_level, 3'd2);
        check("rst_mid_bitlo", {sl0, sl1}, 2'b01);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_lines", {sl0, sl1}, 2'b11);
        check("rst_mid_flush", fifo_level, 3'd0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", tx_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if ({sl0, sl1} != 2'b11 || busy) cnt++;
        end
        check("rst_post_quiet", cnt, 0);
        check("rst_post_level", fifo_level, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
